down_count_monitor: RTL

//  Downstream consumer of the 2-bit asynchronous (ripple) down counter. Samples
//  the counter's q bus into the system clock domain and rejects ripple glitches.

---
 rtl/down_count_monitor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/down_count_monitor.sv
// down_count_monitor
//   Consumer of a small ripple down counter. The raw counter bus is brought into
//   the system clock domain through a two-flop synchronizer, glitch-filtered by
//   requiring STABLE consecutive equal samples, and each accepted value is
//   checked to be exactly one less (mod 2^WIDTH) than the previous accepted value.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_q_in         raw counter bus, asynchronous to i_clk
//   i_clr          synchronous clear of wrap count / error flag, re-acquire
//   o_q_sync       last accepted counter value
//   o_valid        a value has been acquired since reset/clear
//   o_wrap_pulse   one-cycle pulse on an accepted 0 -> max underflow
//   o_wrap_count   number of underflows, modulo 2^WRAP_W
//   o_seq_err      sticky: an accepted value broke the -1 sequence
module down_count_monitor #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned STABLE = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [WIDTH-1:0]  i_q_in,
    input  logic              i_clr,
    output logic [WIDTH-1:0]  o_q_sync,
    output logic              o_valid,
    output logic              o_wrap_pulse,
    output logic [WRAP_W-1:0] o_wrap_count,
    output logic              o_seq_err
);

    localparam int unsigned       STAB_W   = $clog2(STABLE + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);

    typedef enum logic [1:0] {
        StAcq,
        StTrack,
        StErr
    } state_t;

    // Synchronizer and filter state
    logic [WIDTH-1:0]  r_s1;
    logic [WIDTH-1:0]  r_s2;
    logic [STAB_W-1:0] r_stab;

    // Tracking state
    state_t            r_state;
    logic [WIDTH-1:0]  r_q_sync;
    logic              r_valid;
    logic              r_wrap_pulse;
    logic [WRAP_W-1:0] r_wrap_count;
    logic              r_seq_err;

    logic [STAB_W-1:0] w_stab_next;
    logic              w_accept;
    logic [WIDTH-1:0]  w_q_dec;

    state_t            w_state_next;
    logic [WIDTH-1:0]  w_q_sync_next;
    logic              w_valid_next;
    logic              w_wrap_pulse_next;
    logic [WRAP_W-1:0] w_wrap_count_next;
    logic              w_seq_err_next;

    // r_s1 != r_s2 means r_s2 is about to change on this edge, so the run restarts.
    always_comb begin
        w_stab_next = r_stab;
        if (r_s1 != r_s2) begin
            w_stab_next = STAB_ONE;
        end else if (r_stab != STAB_MAX) begin
            w_stab_next = r_stab + STAB_ONE;
        end
    end

    // r_s2 has now been seen STABLE times in a row; a repeat is only taken while acquiring.
    assign w_accept = (r_stab == STAB_MAX) && ((r_state == StAcq) || (r_s2 != r_q_sync));
    assign w_q_dec  = r_q_sync - WIDTH'(1);

    always_comb begin
        w_state_next      = r_state;
        w_q_sync_next     = r_q_sync;
        w_valid_next      = r_valid;
        w_wrap_pulse_next = 1'b0;
        w_wrap_count_next = r_wrap_count;
        w_seq_err_next    = r_seq_err;

        if (i_clr) begin
            w_wrap_count_next = '0;
            w_seq_err_next    = 1'b0;
            if (w_accept) begin
                // A value arriving with clr counts as a fresh acquisition.
                w_q_sync_next = r_s2;
                w_valid_next  = 1'b1;
                w_state_next  = StTrack;
            end else begin
                w_valid_next  = 1'b0;
                w_state_next  = StAcq;
            end
        end else if (w_accept) begin
            w_q_sync_next = r_s2;
            unique case (r_state)
                StAcq: begin
                    w_valid_next = 1'b1;
                    w_state_next = StTrack;
                end
                StTrack: begin
                    if (r_s2 == w_q_dec) begin
                        if (r_q_sync == '0) begin
                            w_wrap_pulse_next = 1'b1;
                            w_wrap_count_next = r_wrap_count + WRAP_W'(1);
                        end
                    end else begin
                        w_seq_err_next = 1'b1;
                        w_state_next   = StErr;
                    end
                end
                StErr: begin
                    w_state_next = StErr;
                end
                default: begin
                    w_state_next = StAcq;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1         <= '0;
            r_s2         <= '0;
            r_stab       <= '0;
            r_state      <= StAcq;
            r_q_sync     <= '0;
            r_valid      <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_wrap_count <= '0;
            r_seq_err    <= 1'b0;
        end else begin
            r_s1         <= i_q_in;
            r_s2         <= r_s1;
            r_stab       <= w_stab_next;
            r_state      <= w_state_next;
            r_q_sync     <= w_q_sync_next;
            r_valid      <= w_valid_next;
            r_wrap_pulse <= w_wrap_pulse_next;
            r_wrap_count <= w_wrap_count_next;
            r_seq_err    <= w_seq_err_next;
        end
    end

    assign o_q_sync     = r_q_sync;
    assign o_valid      = r_valid;
    assign o_wrap_pulse = r_wrap_pulse;
    assign o_wrap_count = r_wrap_count;
    assign o_seq_err    = r_seq_err;

endmodule
